// File: rtl/uart_pkg.sv
`default_nettype none
// uart_pkg: receive FSM state encoding, frame layout and default bit timing.  Rev 1.0
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    SAMPLE    = 3'd2,
    CHECK     = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  localparam int FRAME_BITS           = 10;
  localparam int START_POS            = 0;
  localparam int STOP_POS             = 9;
  localparam int DATA_MSB             = 8;
  localparam int DATA_LSB             = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage
`default_nettype wire

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// uart_rx_ctrl_if: shift-register link and downstream byte port of the UART receiver.  Rev 1.0
interface uart_rx_ctrl_if;
  logic       serial_out;
  logic       shift_en;
  logic [9:0] frame_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;

  modport master (
    output serial_out, shift_en, data_out, data_valid, frame_err,
    input  frame_in
  );

  modport slave (
    input  serial_out, shift_en, data_out, data_valid, frame_err,
    output frame_in
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// uart_rx_sync: 2-flop rx synchroniser with falling-edge pulse; UART_RX_MAJORITY_EN adds
// a 3-sample majority filter.  Rev 1.0
module uart_rx_sync
  import uart_pkg::*;
(
  input  wire logic clk,
  input  wire logic reset,
  input  wire logic rx,
  output logic      bit_out,
  output logic      fall
);
  logic meta;
  logic s0;
  logic prev;
  logic filt;

`ifdef UART_RX_MAJORITY_EN
  logic s1;
  logic s2;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
    end else begin
      s1 <= s0;
      s2 <= s1;
    end
  end

  assign filt = majority3(s0, s1, s2);
`else
  assign filt = s0;
`endif

  // prev tracks the filtered bit so edge detection sees the same value as serial_out
  always_ff @(posedge clk) begin
    if (!reset) begin
      meta <= 1'b1;
      s0   <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= rx;
      s0   <= meta;
      prev <= filt;
    end
  end

  assign bit_out = filt;
  assign fall    = prev & ~filt;
endmodule
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// uart_rx_ctrl: UART receive controller driving an external 10-bit SIPO shift register.
// Optional UART_RX_MAJORITY_EN enables majority filtering of rx.  Rev 1.0
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  wire logic      clk,
  input  wire logic      reset,
  input  wire logic      rx,
  output logic           busy,
  uart_rx_ctrl_if.master bus
);
  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        BITS_LAST = 4'(FRAME_BITS);

  logic              line;
  logic              fall;
  state_t            state, state_nx;
  logic [BAUD_W-1:0] baud_cnt, baud_nx;
  logic [3:0]        bit_cnt, bit_nx;
  logic              shift_q, shift_nx;
  logic [7:0]        data_q, data_nx;
  logic              valid_q, valid_nx;
  logic              err_q, err_nx;

  uart_rx_sync u_sync (
    .clk     (clk),
    .reset   (reset),
    .rx      (rx),
    .bit_out (line),
    .fall    (fall)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= 1'b0;
      data_q   <= 8'h00;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      baud_cnt <= baud_nx;
      bit_cnt  <= bit_nx;
      shift_q  <= shift_nx;
      data_q   <= data_nx;
      valid_q  <= valid_nx;
      err_q    <= err_nx;
      busy     <= (state_nx != IDLE);
    end
  end

  always_comb begin
    state_nx = state;
    baud_nx  = baud_cnt;
    bit_nx   = bit_cnt;
    shift_nx = 1'b0;
    data_nx  = data_q;
    valid_nx = 1'b0;
    err_nx   = 1'b0;
    unique case (state)
      IDLE: begin
        if (fall) begin
          baud_nx  = '0;
          bit_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        if (baud_cnt == HALF_LAST) begin
          baud_nx = '0;
          if (!line) begin
            shift_nx = 1'b1;
            bit_nx   = 4'd1;
            state_nx = SAMPLE;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
      SAMPLE: begin
        // Leave one cycle after the 10th strobe so the register has taken the stop bit
        if (bit_cnt == BITS_LAST) begin
          state_nx = CHECK;
        end else if (baud_cnt == BIT_LAST) begin
          baud_nx  = '0;
          shift_nx = 1'b1;
          bit_nx   = bit_cnt + 4'd1;
        end else begin
          baud_nx = baud_cnt + 1'b1;
        end
      end
      CHECK: begin
        bit_nx  = '0;
        data_nx = bus.frame_in[DATA_MSB:DATA_LSB];
        if (!bus.frame_in[START_POS] && bus.frame_in[STOP_POS]) begin
          valid_nx = 1'b1;
          state_nx = IDLE;
        end else begin
          err_nx   = 1'b1;
          state_nx = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        if (line) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.serial_out = line;
  assign bus.shift_en   = shift_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = err_q;
endmodule
`default_nettype wire

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side controller for the UART. It synchronises the raw rx line and feeds the 10-bit SIPO receive shift register with serial data and a one-cycle shift strobe at each bit centre. When the shift register holds a complete frame, it checks the framing, extracts the byte and presents it downstream with a valid/error pulse.

Parameters:
CLKS_PER_BIT, 5208, system clocks per UART bit (50 MHz / 9600 baud); legal minimum 4
FRAME_BITS, 10, bits per frame: start + 8 data + stop; fixed, to match the shift register width

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-low reset
rx  input  1  asynchronous UART line; idles high
frame_in  input  10  parallel frame from the shift register; [0]=start, [8:1]=D0..D7, [9]=stop
serial_out  output  1  synchronised rx, drives the shift register serial input
shift_en  output  1  one-cycle shift strobe at bit centre, drives the shift register baud-enable input
data_out  output  8  received byte
data_valid  output  1  one-cycle pulse: good frame, data_out valid
frame_err  output  1  one-cycle pulse: bad start or stop bit
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: reset, synchronous, active-low; clock clk. All state updates on posedge clk.
- Reset values: synchroniser flops=1, serial_out=1, shift_en=0, data_out=8'h00, data_valid=0, frame_err=0, busy=0, state=IDLE, counters=0.
- Reset mid-frame: return to IDLE immediately. The shift register shares the same reset, so no partial frame is reported.
- Synchroniser: 2 flops on rx; serial_out = second flop (s0).
- All outputs are registered. Bit counter counts 0..10; baud counter is $clog2(CLKS_PER_BIT) wide.
- IDLE: wait for s0 falling edge (previous=1, current=0). On the edge, clear the baud counter and go to START.
- START: count to CLKS_PER_BIT/2-1.
  - s0 still 0: pulse shift_en, set bit_cnt=1, go to SAMPLE.
  - s0 is 1: treat as glitch; return to IDLE with no shift_en.
- SAMPLE: baud counter wraps at CLKS_PER_BIT-1. At each wrap, pulse shift_en and increment bit_cnt. On the wrap that makes bit_cnt=10, go to CHECK.
  - Exactly 10 shift_en pulses per frame, spaced CLKS_PER_BIT cycles apart.
- CHECK (one cycle; frame_in now holds the full frame):
  - data_out <= frame_in[8:1].
  - frame_in[0]==0 and frame_in[9]==1: data_valid=1 next cycle, go to IDLE.
  - Otherwise: frame_err=1 next cycle, go to WAIT_IDLE.
- Latency: data_valid/frame_err is high in the 2nd cycle after the cycle in which the 10th shift_en is high.
- data_out holds its value until the next CHECK.
- WAIT_IDLE: covers a break or missing stop bit. Stay until s0==1, then go to IDLE. This prevents retriggering on a held-low line.
- Back-to-back frames: control returns to IDLE at mid-stop-bit, so a start edge 1 bit later is caught.
- data_valid and frame_err are mutually exclusive; never both high.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: add a third history flop. serial_out = majority(s0, s1, s2).
  - Start-edge detection and the START mid-bit check use the majority value.
  - Any single-cycle glitch is rejected.
  - Bit-centre timing shifts 1 cycle later, which is acceptable.
- Undefined: serial_out = s0 and there is no extra flop.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, SAMPLE, CHECK, WAIT_IDLE}
  - FRAME_BITS=10, START_POS=0, STOP_POS=9, DATA_MSB=8, DATA_LSB=1
  - default CLKS_PER_BIT
- Sub-module uart_rx_sync: 2-flop synchroniser plus the optional majority filter; outputs the filtered bit and a falling-edge pulse.

Test Plan:
All scenarios use CLKS_PER_BIT=16 with the real shift register attached.
- Send byte 8'hA5 (line: 0,1,0,1,0,0,1,0,1,1) -> exactly 10 shift_en pulses 16 clks apart; data_out=8'hA5; data_valid high 1 cycle; frame_err=0.
- rx low for 3 clks, then high -> no shift_en, state IDLE, busy back to 0; with UART_RX_MAJORITY_EN, a 1-clk low never sets busy.
- Send 8'h5A with stop bit 0, then hold rx low 40 clks -> frame_err 1 cycle; data_out=8'h5A; busy stays 1 until rx returns high; no second frame.
- Assert reset during data bit 4 of 8'h3C, release, then send 8'h3C -> all outputs return to reset values; next frame yields data_out=8'h3C with data_valid.
- Send 8'h00 then 8'hFF back-to-back (one stop bit) -> two data_valid pulses 160 clks apart, values 8'h00 then 8'hFF.
- With UART_RX_MAJORITY_EN, a 1-clk inverted glitch at the centre of D3 of 8'hF0 -> data_out=8'hF0, data_valid.
